// File: rtl/bpb_update_queue_pkg.sv
// Shared types and defaults for the branch predictor update queue.
// Holds the default predictor index width and the queued entry layout.
package bpb_update_queue_pkg;

    localparam int BPQ_IDX_W = 10;

    typedef struct packed {
        logic [BPQ_IDX_W-1:0] index;
        logic                 taken;
    } bpq_entry_t;

endpackage

// File: rtl/bpb_update_queue.sv
// Two-wide commit to one-wide predictor update FIFO (inline circular buffer).
// Optional BPQ_STATS_EN adds pop and commit-stall event counters.
module bpb_update_queue
    import bpb_update_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = BPQ_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c0_valid,
    input  logic [IDX_W-1:0] c0_index,
    input  logic             c0_taken,
    input  logic             c1_valid,
    input  logic [IDX_W-1:0] c1_index,
    input  logic             c1_taken,
    output logic             commit_ready,
    output logic             update_valid,
    output logic [IDX_W-1:0] index_write,
    output logic             update_value
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]      upd_count,
    output logic [31:0]      stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic             tkn_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             push0;
    logic             push1;
    logic             pop;
    logic [PTR_W-1:0] wr1_ptr;
    logic [PTR_W-1:0] tail_nxt;
    logic [PTR_W-1:0] head_nxt;
    logic [CNT_W-1:0] count_nxt;

    // Accept/pop decisions and next pointer/count values
    always_comb begin
        commit_ready = (count <= READY_MAX);
        push0        = commit_ready & c0_valid;
        push1        = commit_ready & c1_valid;
        pop          = (count != '0);
        wr1_ptr      = push0 ? tail + PTR_W'(1) : tail;
        tail_nxt     = tail + PTR_W'(push0) + PTR_W'(push1);
        head_nxt     = head + PTR_W'(pop);
        count_nxt    = count + CNT_W'(push0) + CNT_W'(push1)
                     - CNT_W'(pop);
    end

    // Head entry drives the predictor; outputs forced low when empty
    always_comb begin
        update_valid = pop;
        index_write  = '0;
        update_value = 1'b0;
        if (pop) begin
            index_write  = idx_mem[head];
            update_value = tkn_mem[head];
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    // Entry storage, older branch first, no reset needed
    always_ff @(posedge clk) begin
        if (push0) begin
            idx_mem[tail] <= c0_index;
            tkn_mem[tail] <= c0_taken;
        end
        if (push1) begin
            idx_mem[wr1_ptr] <= c1_index;
            tkn_mem[wr1_ptr] <= c1_taken;
        end
    end

`ifdef BPQ_STATS_EN
    // Event counters: predictor updates issued and stalled commit cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop)
                upd_count <= upd_count + 32'd1;
            if ((c0_valid | c1_valid) & ~commit_ready)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpb_update_queue.sv
// Scoreboard bench for bpb_update_queue: driver pushes expected entries,
// monitor pops and compares whenever an update is presented.
module tb_bpb_update_queue;
    import bpb_update_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             c0_valid = 1'b0;
    logic [IDX_W-1:0] c0_index = '0;
    logic             c0_taken = 1'b0;
    logic             c1_valid = 1'b0;
    logic [IDX_W-1:0] c1_index = '0;
    logic             c1_taken = 1'b0;
    logic             commit_ready;
    logic             update_valid;
    logic [IDX_W-1:0] index_write;
    logic             update_value;
`ifdef BPQ_STATS_EN
    logic [31:0]      upd_count;
    logic [31:0]      stall_count;
`endif

    bpb_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .c0_valid     (c0_valid),
        .c0_index     (c0_index),
        .c0_taken     (c0_taken),
        .c1_valid     (c1_valid),
        .c1_index     (c1_index),
        .c1_taken     (c1_taken),
        .commit_ready (commit_ready),
        .update_valid (update_valid),
        .index_write  (index_write),
        .update_value (update_value)
`ifdef BPQ_STATS_EN
        ,
        .upd_count    (upd_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bpq_entry_t  exp_q[$];
    int          cur_cnt = 0;
    bit          mon_en = 1'b0;
    int unsigned exp_upd = 0;
    int unsigned exp_stall = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compares presented update against scoreboard head
    initial begin
        int n;
        bpq_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                n = exp_q.size();
                cur_cnt = n;
                chk("commit_ready", 32'(commit_ready), 32'(n <= DEPTH - 2));
                chk("update_valid", 32'(update_valid), 32'(n != 0));
`ifdef BPQ_STATS_EN
                chk("upd_count", upd_count, exp_upd);
                chk("stall_count", stall_count, exp_stall);
`endif
                if (n != 0) begin
                    e = exp_q.pop_front();
                    chk("index_write", 32'(index_write), 32'(e.index));
                    chk("update_value", 32'(update_value), 32'(e.taken));
                    exp_upd++;
                end else begin
                    chk("idle_index", 32'(index_write), 32'd0);
                    chk("idle_value", 32'(update_value), 32'd0);
                end
            end
        end
    end

    // Driver: applies one commit cycle and records accepted branches
    task automatic drive(bit v0, logic [IDX_W-1:0] i0, bit t0,
                         bit v1, logic [IDX_W-1:0] i1, bit t1);
        @(negedge clk);
        c0_valid = v0; c0_index = i0; c0_taken = t0;
        c1_valid = v1; c1_index = i1; c1_taken = t1;
        if (cur_cnt <= DEPTH - 2) begin
            if (v0) exp_q.push_back('{index: i0, taken: t0});
            if (v1) exp_q.push_back('{index: i1, taken: t1});
        end else if (v0 | v1) begin
            exp_stall++;
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 4 * DEPTH) begin
            idle();
            k++;
        end
        idle();
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int k;
        #2;
        chk("rst_valid", 32'(update_valid), 32'd0);
        chk("rst_ready", 32'(commit_ready), 32'd1);
        chk("rst_index", 32'(index_write), 32'd0);
        chk("rst_value", 32'(update_value), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cur_cnt = 0;
        mon_en = 1'b1;

        repeat (10) idle();

        drive(1'b1, 10'h155, 1'b1, 1'b0, '0, 1'b0);
        repeat (3) idle();

        repeat (20) drive(1'b1, 10'h001, 1'b0, 1'b1, 10'h002, 1'b1);
        drain();

        drive(1'b0, '0, 1'b0, 1'b1, 10'h3FF, 1'b1);
        drain();

        repeat (400) begin
            drive(($urandom % 4) != 0, IDX_W'($urandom), 1'($urandom),
                  ($urandom % 4) != 0, IDX_W'($urandom), 1'($urandom));
        end
        drain();

        k = 0;
        while (k < 50) begin
            @(posedge clk);
            #2;
            if (cur_cnt == 5) break;
            drive(1'b1, IDX_W'($urandom), 1'($urandom),
                  1'b1, IDX_W'($urandom), 1'($urandom));
            k++;
        end
        chk("pre_reset_cnt", 32'(cur_cnt), 32'd5);
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(update_valid), 32'd0);
        chk("async_ready", 32'(commit_ready), 32'd1);
        chk("async_index", 32'(index_write), 32'd0);
        mon_en = 1'b0;
        exp_q.delete();
        exp_upd = 0;
        exp_stall = 0;
        c0_valid = 1'b0;
        c1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cur_cnt = 0;
        mon_en = 1'b1;
        repeat (3) idle();

        drive(1'b1, 10'h2A5, 1'b0, 1'b1, 10'h15A, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpb_update_queue.md
BPB_UPDATE_QUEUE -- requirements
Module: bpb_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning queue entries; legal values are powers of two, 4 to 64.
REQ-002 The block SHALL have parameter IDX_W, default 10, meaning the predictor index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port c0_valid, input, 1 bit: the older committing branch is present this cycle.
REQ-006 The block SHALL have port c0_index, input, IDX_W bits: the predictor index of the older branch.
REQ-007 The block SHALL have port c0_taken, input, 1 bit: resolved outcome of the older branch.
REQ-008 The block SHALL have ports c1_valid, c1_index and c1_taken, with the same widths and meanings as the c0 ports, for the younger branch.
REQ-009 The block SHALL have port commit_ready, output, 1 bit: the queue can accept two entries this cycle.
REQ-010 The block SHALL have port update_valid, output, 1 bit: a predictor update is presented this cycle.
REQ-011 The block SHALL have port index_write, output, IDX_W bits: the predictor index to update.
REQ-012 The block SHALL have port update_value, output, 1 bit: the taken outcome to train.

Function
REQ-013 Storage SHALL be a circular FIFO of DEPTH entries {index, taken}, with head and tail pointers of clog2(DEPTH) bits and a count of clog2(DEPTH)+1 bits.
REQ-014 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 commit_ready SHALL be 1 exactly when the registered count is <= DEPTH-2.
- It is combinational from count only, with no dependency on c*_valid.
REQ-016 Writes SHALL occur only when commit_ready=1; c*_valid while commit_ready=0 SHALL be ignored.
- Commit is required to hold its branches; they are not lost silently.
REQ-017 Write ordering SHALL be as follows:
- c0 is written before c1.
- If only c1_valid=1, c1 is written alone at tail.
- If both are valid, c0 goes to tail and c1 to tail+1.
REQ-018 update_valid SHALL equal (count != 0); index_write and update_value SHALL be driven combinationally from the head entry.
REQ-019 The consumer always accepts an update, so the head SHALL be popped on every cycle that update_valid=1.
REQ-020 The count SHALL be updated as next count = count + pushes - pop, where pushes is 0 to 2 and pop is 0 to 1, and SHALL never exceed DEPTH.
REQ-021 Push-to-output latency SHALL be one cycle: an entry written at edge N appears at head no earlier than the cycle after edge N.
- Same-cycle bypass of c*_* to the outputs is prohibited.
REQ-022 For simultaneous push and pop with count=0: the pushes are written, nothing is popped, and count becomes the number of pushes.
REQ-023 For simultaneous push and pop with count=DEPTH-2: with 2 pushes and 1 pop, count becomes DEPTH-1 and commit_ready falls.
REQ-024 When empty, index_write and update_value SHALL be held at 0.

Reset
REQ-025 While reset=0, asynchronously, the block SHALL clear head, tail and count, which drives update_valid=0, index_write=0, update_value=0 and commit_ready=1.
REQ-026 Entry storage need not be reset.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries, with no partial pop or push completing.

Configuration
REQ-028 With BPQ_STATS_EN defined, the block SHALL add output ports upd_count (32 bits) and stall_count (32 bits).
- upd_count increments on each pop.
- stall_count increments on each cycle with (c0_valid | c1_valid) & ~commit_ready.
- Both reset to 0 and wrap modulo 2^32.
REQ-029 Without BPQ_STATS_EN, those ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 A shared package SHALL hold the IDX_W default constant (10) and the typedef bpq_entry_t {logic [IDX_W-1:0] index; logic taken;}.
REQ-031 There SHALL be no sub-module; the FIFO is inline.
- The downstream 1024-entry two-bit predictor table connects via update_valid, index_write and update_value.

Verification
REQ-032 Reset then idle: all outputs 0 except commit_ready=1 for 10 cycles.
REQ-033 Single push c0={0x155,1} at cycle 1: next cycle update_valid=1, index_write=0x155, update_value=1; the cycle after that, update_valid=0.
REQ-034 Dual pushes {0x001,0},{0x002,1} every cycle with DEPTH=8:
- Outputs pop 0x001,0x002,0x001,... in order.
- commit_ready drops to 0 once count reaches 7, then rises at count 6.
- No entry is lost or duplicated, checked against a scoreboard.
REQ-035 c1-only push {0x3FF,1} with c0_valid=0: a single entry 0x3FF is output.
REQ-036 Pushes with commit_ready=0: the entries are not stored; stall_count increments by one per such cycle when BPQ_STATS_EN is defined.
REQ-037 reset asserted asynchronously mid-cycle with 5 entries queued: update_valid falls immediately, and after release the queue is empty with commit_ready=1.
